// File: rtl/fetch_redirect_if.sv
// Fetch-side bundle between the redirect controller, the i-memory, decode and
// the redirect requesters. master = controller, slave = its environment.
interface fetch_redirect_if #(
    parameter int MAX_INFLIGHT = 2
);
    localparam int CW = $clog2(MAX_INFLIGHT + 1);

    // Redirect requests: a request is sampled in the cycle it is high; there is
    // no ready, the controller holds the winning one internally until it applies.
    // I-memory address channel: the address transfers when pc_valid & pc_ready,
    // and fetch_pc holds while pc_valid & ~pc_ready.
    // Response channel: consumed when inst_valid & inst_ready; inst_keep marks
    // a consumed, non-stale response.
    logic                exc_req;
    logic [31:0]         exc_pc;
    logic                br_req;
    logic [31:0]         br_pc;
    logic                replay_req;
    logic [31:0]         replay_pc;
    logic                pc_valid;
    logic                pc_ready;
    logic [31:0]         fetch_pc;
    logic                inst_valid;
    logic                inst_ready;
    logic                inst_keep;
    logic                busy;
    logic [CW-1:0]       inflight;
    logic [1:0]          dbg_state;

    modport master (
        input  exc_req, exc_pc, br_req, br_pc, replay_req, replay_pc,
        input  pc_ready, inst_valid, inst_ready,
        output pc_valid, fetch_pc, inst_keep, busy, inflight, dbg_state
    );

    modport slave (
        output exc_req, exc_pc, br_req, br_pc, replay_req, replay_pc,
        output pc_ready, inst_valid, inst_ready,
        input  pc_valid, fetch_pc, inst_keep, busy, inflight, dbg_state
    );
endinterface

// File: rtl/fetch_redirect_ctrl.sv
// Fetch PC sequencer: issues sequential fetch addresses, arbitrates redirects by
// fixed priority and suppresses responses of fetches overtaken by a redirect.
module fetch_redirect_ctrl #(
    parameter logic [31:0] RESET_PC     = 32'hbfc00000,
    parameter int          MAX_INFLIGHT = 2
) (
    input  logic             clk,
    input  logic             reset,
    fetch_redirect_if.master bus
);
    localparam int CW = $clog2(MAX_INFLIGHT + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_INFLIGHT);

    localparam logic [1:0] PRI_EXC    = 2'd0;
    localparam logic [1:0] PRI_BR     = 2'd1;
    localparam logic [1:0] PRI_REPLAY = 2'd2;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_REDIRECT = 2'd1,
        ST_DRAIN    = 2'd2
    } state_e;

    logic [31:0]   pc_q, pc_d;
    logic          pend_v_q, pend_v_d;
    logic [31:0]   pend_pc_q, pend_pc_d;
    logic [1:0]    pend_pri_q, pend_pri_d;
    logic [CW-1:0] infl_q, infl_d;
    logic [CW-1:0] stale_q, stale_d;
    state_e        state_q, state_d;

    logic          pc_valid;
    logic          hs;
    logic          rsp;
    logic          rsp_ok;
    logic          eff_v;
    logic [31:0]   eff_pc;
    logic [1:0]    eff_pri;
    logic          apply;

    assign pc_valid = ~reset & (infl_q < MAX_CNT);
    assign hs       = pc_valid & bus.pc_ready;
    assign rsp      = bus.inst_valid & bus.inst_ready;
    // A response with nothing outstanding is ignored so the counter cannot wrap.
    assign rsp_ok   = rsp & (infl_q != '0);

    // New requests win ties against the held entry, hence the interleaving.
    always_comb begin
        eff_v   = pend_v_q | bus.exc_req | bus.br_req | bus.replay_req;
        eff_pc  = pend_pc_q;
        eff_pri = pend_pri_q;
        if (bus.exc_req) begin
            eff_pc  = bus.exc_pc;
            eff_pri = PRI_EXC;
        end else if (pend_v_q && pend_pri_q == PRI_EXC) begin
            eff_pc  = pend_pc_q;
            eff_pri = pend_pri_q;
        end else if (bus.br_req) begin
            eff_pc  = bus.br_pc;
            eff_pri = PRI_BR;
        end else if (pend_v_q && pend_pri_q == PRI_BR) begin
            eff_pc  = pend_pc_q;
            eff_pri = pend_pri_q;
        end else if (bus.replay_req) begin
            eff_pc  = bus.replay_pc;
            eff_pri = PRI_REPLAY;
        end
    end

    // Only change the address once the current one has transferred or none is offered.
    assign apply = eff_v & (hs | ~pc_valid);

    always_comb begin
        pc_d       = pc_q;
        pend_v_d   = pend_v_q;
        pend_pc_d  = pend_pc_q;
        pend_pri_d = pend_pri_q;
        infl_d     = infl_q + CW'(hs) - CW'(rsp_ok);
        stale_d    = stale_q;
        state_d    = state_q;

        if (apply) begin
            pc_d     = eff_pc;
            pend_v_d = 1'b0;
        end else if (eff_v) begin
            pend_v_d   = 1'b1;
            pend_pc_d  = eff_pc;
            pend_pri_d = eff_pri;
        end else if (hs) begin
            pc_d = pc_q + 32'd4;
        end

        // Every fetch outstanding after this edge is on the wrong path.
        if (eff_v) begin
            stale_d = infl_d;
        end else if (rsp && stale_q != '0) begin
            stale_d = stale_q - CW'(1);
        end

        if (pend_v_d) begin
            state_d = ST_REDIRECT;
        end else if (stale_d != '0) begin
            state_d = ST_DRAIN;
        end else begin
            state_d = ST_RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q       <= RESET_PC;
            pend_v_q   <= 1'b0;
            pend_pc_q  <= '0;
            pend_pri_q <= '0;
            infl_q     <= '0;
            stale_q    <= '0;
            state_q    <= ST_RUN;
        end else begin
            pc_q       <= pc_d;
            pend_v_q   <= pend_v_d;
            pend_pc_q  <= pend_pc_d;
            pend_pri_q <= pend_pri_d;
            infl_q     <= infl_d;
            stale_q    <= stale_d;
            state_q    <= state_d;
        end
    end

    assign bus.pc_valid  = pc_valid;
    assign bus.fetch_pc  = pc_q;
    // Registered stale count: a response in the same cycle as a redirect is kept.
    assign bus.inst_keep = ~reset & rsp & (stale_q == '0);
    assign bus.busy      = ~reset & (pend_v_q | (stale_q != '0));
    assign bus.inflight  = infl_q;
    assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Bench for fetch_redirect_ctrl: directed scenarios then random traffic, all
// checked every cycle against a queue-of-fetches reference model.
module tb_fetch_redirect_ctrl;
    localparam logic [31:0] RESET_PC = 32'hbfc00000;
    localparam int          MAX_INFL = 2;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    fetch_redirect_if #(.MAX_INFLIGHT(MAX_INFL)) bus ();

    fetch_redirect_ctrl #(
        .RESET_PC     (RESET_PC),
        .MAX_INFLIGHT (MAX_INFL)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Model: current fetch address, held redirect, outstanding fetches {stale, addr}.
    logic [31:0] m_pc;
    logic        m_pend_v;
    logic [31:0] m_pend_pc;
    int          m_pend_pri;
    logic [32:0] exp_q[$];

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic int n_stale();
        int n = 0;
        foreach (exp_q[i]) if (exp_q[i][32]) n++;
        return n;
    endfunction

    function automatic logic exp_pc_valid();
        return !reset && (exp_q.size() < MAX_INFL);
    endfunction

    task automatic model_reset();
        m_pc       = RESET_PC;
        m_pend_v   = 1'b0;
        m_pend_pc  = '0;
        m_pend_pri = 3;
        exp_q.delete();
    endtask

    task automatic sample();
        logic rsp;
        logic keep;
        int   st;
        @(negedge clk);
        rsp  = bus.inst_valid && bus.inst_ready;
        st   = n_stale();
        keep = !reset && rsp && (exp_q.size() == 0 || !exp_q[0][32]);
        check_val("fetch_pc", bus.fetch_pc, m_pc);
        check_val("pc_valid", 32'(bus.pc_valid), 32'(exp_pc_valid()));
        check_val("inst_keep", 32'(bus.inst_keep), 32'(keep));
        check_val("busy", 32'(bus.busy), 32'(!reset && (m_pend_v || st > 0)));
        check_val("inflight", 32'(bus.inflight), 32'(exp_q.size()));
        check_val("state", 32'(bus.dbg_state), m_pend_v ? 32'd1 : (st > 0 ? 32'd2 : 32'd0));
    endtask

    task automatic advance();
        logic        pcv, hs, rsp, eff_v;
        logic [31:0] eff_pc;
        int          eff_pri;
        logic        req [3];
        logic [31:0] tgt [3];
        logic [32:0] e;
        pcv = exp_pc_valid();
        hs  = pcv && bus.pc_ready;
        rsp = bus.inst_valid && bus.inst_ready;
        if (reset) begin
            model_reset();
        end else begin
            req[0] = bus.exc_req;    tgt[0] = bus.exc_pc;
            req[1] = bus.br_req;     tgt[1] = bus.br_pc;
            req[2] = bus.replay_req; tgt[2] = bus.replay_pc;
            eff_v   = m_pend_v;
            eff_pc  = m_pend_pc;
            eff_pri = m_pend_v ? m_pend_pri : 3;
            for (int p = 0; p < 3; p++) begin
                if (req[p] && p <= eff_pri) begin
                    eff_v   = 1'b1;
                    eff_pc  = tgt[p];
                    eff_pri = p;
                end
            end
            if (rsp && exp_q.size() > 0) exp_q.delete(0);
            if (hs) exp_q.push_back({1'b0, m_pc});
            if (eff_v) begin
                for (int i = 0; i < exp_q.size(); i++) begin
                    e = exp_q[i];
                    e[32] = 1'b1;
                    exp_q[i] = e;
                end
            end
            if (eff_v && (hs || !pcv)) begin
                m_pc     = eff_pc;
                m_pend_v = 1'b0;
            end else if (eff_v) begin
                m_pend_v   = 1'b1;
                m_pend_pc  = eff_pc;
                m_pend_pri = eff_pri;
            end else if (hs) begin
                m_pc = m_pc + 32'd4;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic cycle();
        sample();
        advance();
    endtask

    task automatic set_idle();
        bus.exc_req    = 1'b0;
        bus.exc_pc     = '0;
        bus.br_req     = 1'b0;
        bus.br_pc      = '0;
        bus.replay_req = 1'b0;
        bus.replay_pc  = '0;
        bus.pc_ready   = 1'b0;
        bus.inst_valid = 1'b0;
        bus.inst_ready = 1'b1;
    endtask

    task automatic rand_inputs();
        reset          = ($urandom_range(0, 299) == 0);
        bus.exc_req    = ($urandom_range(0, 19) == 0);
        bus.exc_pc     = $urandom;
        bus.br_req     = ($urandom_range(0, 7) == 0);
        bus.br_pc      = $urandom;
        bus.replay_req = ($urandom_range(0, 9) == 0);
        bus.replay_pc  = $urandom;
        bus.pc_ready   = ($urandom_range(0, 3) != 0);
        bus.inst_valid = !reset && exp_q.size() > 0 && ($urandom_range(0, 2) != 0);
        bus.inst_ready = ($urandom_range(0, 3) != 0);
    endtask

    initial begin
        reset = 1'b1;
        set_idle();
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        cycle();

        // Sequential fetch with one-cycle responses.
        reset = 1'b0;
        bus.pc_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            bus.inst_valid = (exp_q.size() > 0);
            sample();
            check_val("t1_pc", bus.fetch_pc, RESET_PC + 32'(4 * k));
            check_val("t1_keep", 32'(bus.inst_keep), (k > 0) ? 32'd1 : 32'd0);
            check_val("t1_infl", 32'(bus.inflight), (k > 0) ? 32'd1 : 32'd0);
            advance();
        end

        // Branch held while the address is stalled.
        bus.pc_ready = 1'b0; bus.inst_valid = 1'b0;
        bus.br_req = 1'b1; bus.br_pc = 32'h80001000;
        sample();
        check_val("t2_hold0", bus.fetch_pc, 32'hbfc0000c);
        check_val("t2_busy0", 32'(bus.busy), 32'd0);
        advance();
        bus.br_req = 1'b0;
        for (int k = 0; k < 2; k++) begin
            sample();
            check_val("t2_hold", bus.fetch_pc, 32'hbfc0000c);
            check_val("t2_busy", 32'(bus.busy), 32'd1);
            advance();
        end
        bus.pc_ready = 1'b1;
        sample();
        check_val("t2_old_issue", bus.fetch_pc, 32'hbfc0000c);
        advance();
        bus.pc_ready = 1'b0;
        sample();
        check_val("t2_target", bus.fetch_pc, 32'h80001000);
        check_val("t2_infl", 32'(bus.inflight), 32'd2);
        check_val("t2_pcv", 32'(bus.pc_valid), 32'd0);
        advance();
        bus.inst_valid = 1'b1;
        for (int k = 0; k < 2; k++) begin
            sample();
            check_val("t2_stale_keep", 32'(bus.inst_keep), 32'd0);
            advance();
        end
        bus.inst_valid = 1'b0;
        sample();
        check_val("t2_busy_end", 32'(bus.busy), 32'd0);
        advance();

        // Exception beats a same-cycle branch and a held replay.
        bus.replay_req = 1'b1; bus.replay_pc = 32'h12345678;
        cycle();
        bus.replay_req = 1'b0;
        sample();
        check_val("t3_pend", 32'(bus.busy), 32'd1);
        advance();
        bus.exc_req = 1'b1; bus.exc_pc = 32'hbfc00380;
        bus.br_req = 1'b1;  bus.br_pc = 32'h80002000;
        bus.pc_ready = 1'b1;
        sample();
        check_val("t3_pre", bus.fetch_pc, 32'h80001000);
        advance();
        bus.exc_req = 1'b0; bus.br_req = 1'b0;
        sample();
        check_val("t3_exc", bus.fetch_pc, 32'hbfc00380);
        advance();
        bus.pc_ready = 1'b0;
        sample();
        check_val("t3_dropped", bus.fetch_pc, 32'hbfc00384);
        advance();
        bus.inst_valid = 1'b1;
        sample();
        check_val("t3_keep_stale", 32'(bus.inst_keep), 32'd0);
        advance();
        sample();
        check_val("t3_keep_good", 32'(bus.inst_keep), 32'd1);
        advance();
        bus.inst_valid = 1'b0;
        cycle();

        // Redirect with the fetch window full applies at once.
        bus.pc_ready = 1'b1;
        cycle();
        cycle();
        bus.pc_ready = 1'b0;
        bus.br_req = 1'b1; bus.br_pc = 32'h90000000;
        sample();
        check_val("t4_pcv", 32'(bus.pc_valid), 32'd0);
        advance();
        bus.br_req = 1'b0;
        sample();
        check_val("t4_target", bus.fetch_pc, 32'h90000000);
        check_val("t4_infl", 32'(bus.inflight), 32'd2);
        advance();
        bus.inst_valid = 1'b1;
        for (int k = 0; k < 2; k++) begin
            sample();
            check_val("t4_stale_keep", 32'(bus.inst_keep), 32'd0);
            advance();
        end
        bus.inst_valid = 1'b0;
        sample();
        check_val("t4_busy_end", 32'(bus.busy), 32'd0);
        advance();
        bus.pc_ready = 1'b1;
        cycle();
        bus.pc_ready = 1'b0; bus.inst_valid = 1'b1;
        sample();
        check_val("t4_keep_new", 32'(bus.inst_keep), 32'd1);
        advance();
        bus.inst_valid = 1'b0;

        // Decode stall holds responses.
        bus.pc_ready = 1'b1; bus.br_req = 1'b1; bus.br_pc = 32'ha0000000;
        cycle();
        bus.pc_ready = 1'b0; bus.br_req = 1'b0;
        bus.inst_valid = 1'b1; bus.inst_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            sample();
            check_val("t5_stall_keep", 32'(bus.inst_keep), 32'd0);
            check_val("t5_stall_infl", 32'(bus.inflight), 32'd1);
            check_val("t5_stall_busy", 32'(bus.busy), 32'd1);
            advance();
        end
        bus.inst_ready = 1'b1;
        cycle();
        bus.inst_valid = 1'b0;
        sample();
        check_val("t5_busy_end", 32'(bus.busy), 32'd0);
        advance();
        bus.pc_ready = 1'b1;
        cycle();
        bus.pc_ready = 1'b0; bus.inst_valid = 1'b1; bus.inst_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            sample();
            check_val("t5_hold_keep", 32'(bus.inst_keep), 32'd0);
            advance();
        end
        bus.inst_ready = 1'b1;
        sample();
        check_val("t5_release_keep", 32'(bus.inst_keep), 32'd1);
        advance();
        bus.inst_valid = 1'b0;

        // Reset while redirecting with a stale fetch outstanding; then PC wrap.
        bus.pc_ready = 1'b1; bus.br_req = 1'b1; bus.br_pc = 32'hc0000000;
        cycle();
        bus.pc_ready = 1'b0; bus.br_req = 1'b0;
        bus.replay_req = 1'b1; bus.replay_pc = 32'hd0000000;
        cycle();
        bus.replay_req = 1'b0;
        reset = 1'b1;
        sample();
        check_val("t6_rst_pcv", 32'(bus.pc_valid), 32'd0);
        advance();
        sample();
        check_val("t6_rst_busy", 32'(bus.busy), 32'd0);
        check_val("t6_rst_infl", 32'(bus.inflight), 32'd0);
        advance();
        reset = 1'b0;
        sample();
        check_val("t6_restart_pc", bus.fetch_pc, RESET_PC);
        check_val("t6_restart_pcv", 32'(bus.pc_valid), 32'd1);
        advance();
        bus.br_req = 1'b1; bus.br_pc = 32'hfffffffc; bus.pc_ready = 1'b1;
        cycle();
        bus.br_req = 1'b0;
        sample();
        check_val("t6_top", bus.fetch_pc, 32'hfffffffc);
        advance();
        bus.pc_ready = 1'b0;
        sample();
        check_val("t6_wrap", bus.fetch_pc, 32'h00000000);
        advance();

        for (int n = 0; n < 3000; n++) begin
            rand_inputs();
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
